// File: rtl/p405s_icu_bist_pkg.sv
// Shared types and constants for the ICU data-array March C- BIST.
// P405S_ICU_BIST_CKBD_EN adds a second checkerboard pass and widens the element code.
package p405s_icu_bist_pkg;

`ifdef P405S_ICU_BIST_CKBD_EN
  localparam int BIST_ELEM_W = 4;
`else
  localparam int BIST_ELEM_W = 3;
`endif

  localparam logic [127:0] BG_SOLID = '0;
  localparam logic [127:0] BG_CKBD  = {64{2'b01}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } bist_state_e;

  typedef enum logic [2:0] {
    ELEM_M0 = 3'd0,
    ELEM_M1 = 3'd1,
    ELEM_M2 = 3'd2,
    ELEM_M3 = 3'd3,
    ELEM_M4 = 3'd4,
    ELEM_M5 = 3'd5
  } bist_elem_e;

  // rd_inv/wr_inv select ~B instead of B for the read-expect and write data.
  typedef struct packed {
    logic descend;
    logic has_read;
    logic has_write;
    logic rd_inv;
    logic wr_inv;
  } elem_info_t;

  function automatic logic elem_is_desc(bist_elem_e e);
    return (e == ELEM_M3) || (e == ELEM_M4);
  endfunction

  function automatic elem_info_t elem_info(bist_elem_e e);
    elem_info_t i;
    i = '0;
    i.descend = elem_is_desc(e);
    case (e)
      ELEM_M0: i.has_write = 1'b1;
      ELEM_M1, ELEM_M3: begin
        i.has_read  = 1'b1;
        i.has_write = 1'b1;
        i.wr_inv    = 1'b1;
      end
      ELEM_M2, ELEM_M4: begin
        i.has_read  = 1'b1;
        i.has_write = 1'b1;
        i.rd_inv    = 1'b1;
      end
      ELEM_M5: i.has_read = 1'b1;
      default: ;
    endcase
    return i;
  endfunction

endpackage

// File: rtl/p405s_icu_bist_cmp.sv
// Read-compare pipeline: registers the expected word of each read and checks the
// array data one cycle later, capturing only the first failing address/element.
module p405s_icu_bist_cmp
  import p405s_icu_bist_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 128
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   rd_i,
  input  logic [DATA_W-1:0]      exp_data_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [BIST_ELEM_W-1:0] elem_i,
  input  logic [DATA_W-1:0]      rd_data_i,
  output logic                   fail_o,
  output logic [ADDR_W-1:0]      fail_addr_o,
  output logic [BIST_ELEM_W-1:0] fail_elem_o
);

  logic                   vld_q;
  logic [DATA_W-1:0]      exp_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [BIST_ELEM_W-1:0] elem_q;
  logic                   fail_q, fail_d;
  logic [ADDR_W-1:0]      faddr_q, faddr_d;
  logic [BIST_ELEM_W-1:0] felem_q, felem_d;
  logic                   mismatch;

  assign mismatch = vld_q && (rd_data_i != exp_q);

  always_comb begin
    fail_d  = fail_q;
    faddr_d = faddr_q;
    felem_d = felem_q;
    if (clear_i) begin
      fail_d  = 1'b0;
      faddr_d = '0;
      felem_d = '0;
    end else if (mismatch && !fail_q) begin
      fail_d  = 1'b1;
      faddr_d = addr_q;
      felem_d = elem_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q   <= 1'b0;
      exp_q   <= '0;
      addr_q  <= '0;
      elem_q  <= '0;
      fail_q  <= 1'b0;
      faddr_q <= '0;
      felem_q <= '0;
    end else begin
      vld_q <= rd_i;
      if (rd_i) begin
        exp_q  <= exp_data_i;
        addr_q <= addr_i;
        elem_q <= elem_i;
      end
      fail_q  <= fail_d;
      faddr_q <= faddr_d;
      felem_q <= felem_d;
    end
  end

  assign fail_o      = fail_q;
  assign fail_addr_o = faddr_q;
  assign fail_elem_o = felem_q;

endmodule

// File: rtl/p405s_icu_ram_bist_ctl.sv
// March C- BIST controller for one ICU data-array way (FSM plus element/address/phase counters).
// Define P405S_ICU_BIST_CKBD_EN to append a checkerboard-background pass after the solid pass.
module p405s_icu_ram_bist_ctl
  import p405s_icu_bist_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 128
) (
  input  logic                   CB,
  input  logic                   rstN,
  input  logic                   bist_start,
  input  logic [DATA_W-1:0]      bist_rd_data,
  output logic                   bist_mode,
  output logic                   bist_ce_n,
  output logic                   bist_we_n,
  output logic [ADDR_W-1:0]      bist_addr,
  output logic [DATA_W-1:0]      bist_wr_data,
  output logic                   bist_busy,
  output logic                   bist_done,
  output logic                   bist_fail,
  output logic [ADDR_W-1:0]      bist_fail_addr,
  output logic [BIST_ELEM_W-1:0] bist_fail_elem
);

  localparam logic [ADDR_W-1:0] AddrMax = '1;

  bist_state_e            state_q, state_d;
  bist_elem_e             elem_q, elem_d, elem_nxt;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   phase_q, phase_d;
  logic                   pass_q;
  elem_info_t             info;
  logic                   run, start_acc, is_rd, is_wr, elem_end;
  logic [DATA_W-1:0]      bg, rd_exp, wr_pat;
  logic [BIST_ELEM_W-1:0] cur_elem;

`ifdef P405S_ICU_BIST_CKBD_EN
  logic pass_d;

  always_ff @(posedge CB) begin
    if (!rstN) pass_q <= 1'b0;
    else       pass_q <= pass_d;
  end

  assign cur_elem = {pass_q, elem_q};
`else
  assign pass_q   = 1'b0;
  assign cur_elem = elem_q;
`endif

  assign info      = elem_info(elem_q);
  assign elem_nxt  = bist_elem_e'(elem_q + 3'd1);
  assign run       = (state_q == ST_RUN);
  assign start_acc = bist_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  // Read-write elements spend phase 0 reading and phase 1 writing the same address.
  assign is_rd     = run && info.has_read && !phase_q;
  assign is_wr     = run && info.has_write && (phase_q || !info.has_read);
  assign elem_end  = info.descend ? (addr_q == '0) : (addr_q == AddrMax);
  assign bg        = pass_q ? DATA_W'(BG_CKBD) : DATA_W'(BG_SOLID);
  assign rd_exp    = bg ^ {DATA_W{info.rd_inv}};
  assign wr_pat    = bg ^ {DATA_W{info.wr_inv}};

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    addr_d  = addr_q;
    phase_d = phase_q;
`ifdef P405S_ICU_BIST_CKBD_EN
    pass_d  = pass_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bist_start) begin
          state_d = ST_RUN;
          elem_d  = ELEM_M0;
          addr_d  = '0;
          phase_d = 1'b0;
`ifdef P405S_ICU_BIST_CKBD_EN
          pass_d  = 1'b0;
`endif
        end
      end
      ST_RUN: begin
        if (info.has_read && info.has_write && !phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          addr_d  = info.descend ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
          // Element boundary: jump straight to the next element's start address, no gap.
          if (elem_end) begin
            if (elem_q == ELEM_M5) begin
              elem_d = ELEM_M0;
              addr_d = '0;
`ifdef P405S_ICU_BIST_CKBD_EN
              if (pass_q) state_d = ST_DRAIN;
              else        pass_d  = 1'b1;
`else
              state_d = ST_DRAIN;
`endif
            end else begin
              elem_d = elem_nxt;
              addr_d = elem_is_desc(elem_nxt) ? AddrMax : '0;
            end
          end
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CB) begin
    if (!rstN) begin
      state_q <= ST_IDLE;
      elem_q  <= ELEM_M0;
      addr_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
    end
  end

  p405s_icu_bist_cmp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_cmp (
    .clk_i       (CB),
    .rst_ni      (rstN),
    .clear_i     (start_acc),
    .rd_i        (is_rd),
    .exp_data_i  (rd_exp),
    .addr_i      (addr_q),
    .elem_i      (cur_elem),
    .rd_data_i   (bist_rd_data),
    .fail_o      (bist_fail),
    .fail_addr_o (bist_fail_addr),
    .fail_elem_o (bist_fail_elem)
  );

  assign bist_mode    = run || (state_q == ST_DRAIN);
  assign bist_busy    = run || (state_q == ST_DRAIN);
  assign bist_done    = (state_q == ST_DONE);
  assign bist_ce_n    = !run;
  assign bist_we_n    = !is_wr;
  assign bist_addr    = addr_q;
  assign bist_wr_data = is_wr ? wr_pat : '0;

endmodule
